// File: rtl/hicore_rob.sv
// hicore_rob: in-order reorder buffer between dispatch/writeback and the commit stage
`ifndef HiCore_RFIDX_WIDTH
`define HiCore_RFIDX_WIDTH 5
`endif
`ifndef HiCore_CSRIDX_WIDTH
`define HiCore_CSRIDX_WIDTH 12
`endif
`ifndef HiCore_PC_SIZE
`define HiCore_PC_SIZE 32
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_EXCP_SIZE
`define HiCore_EXCP_SIZE 8
`endif
`ifndef HiCore_IRQ_SIZE
`define HiCore_IRQ_SIZE 3
`endif
`ifndef HiCore_WB_SIZE
`define HiCore_WB_SIZE (`HiCore_PC_SIZE + `HiCore_IRQ_SIZE + `HiCore_EXCP_SIZE)
`endif

module hicore_rob #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic                             disp_rd_need,
    input  logic [`HiCore_RFIDX_WIDTH-1:0]   disp_rd_idx,
    input  logic                             disp_csr_need,
    input  logic [`HiCore_CSRIDX_WIDTH-1:0]  disp_csr_idx,
    input  logic                             disp_fence_i_op,
    input  logic                             disp_mret_op,
    input  logic [`HiCore_PC_SIZE-1:0]       disp_pc,
    output logic [TAG_W-1:0]                 disp_tag,
    input  logic                             wb_valid,
    input  logic [TAG_W-1:0]                 wb_tag,
    input  logic [`HiCore_REG_SIZE-1:0]      wb_rd_data,
    input  logic [`HiCore_REG_SIZE-1:0]      wb_csr_data,
    input  logic [`HiCore_PC_SIZE-1:0]       wb_next_pc,
    input  logic [`HiCore_EXCP_SIZE-1:0]     wb_excp,
    input  logic [`HiCore_IRQ_SIZE-1:0]      wb_irq,
    input  logic                             rob_valid,
    output logic                             rob_ready,
    output logic                             rob_rd_need,
    output logic [`HiCore_RFIDX_WIDTH-1:0]   rob_rd_idx,
    output logic [`HiCore_REG_SIZE-1:0]      rob_rd_data,
    output logic                             rob_csr_need,
    output logic [`HiCore_CSRIDX_WIDTH-1:0]  rob_csr_idx,
    output logic [`HiCore_REG_SIZE-1:0]      rob_csr_data,
    output logic                             rob_fence_i_op,
    output logic                             rob_mret_op,
    output logic [`HiCore_PC_SIZE-1:0]       rob_next_pc,
    output logic [`HiCore_WB_SIZE-1:0]       rob_info,
    input  logic                             flush
);
    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count;
    logic [DEPTH-1:0] valid, done;
    logic                            rd_need_q  [DEPTH];
    logic [`HiCore_RFIDX_WIDTH-1:0]  rd_idx_q   [DEPTH];
    logic                            csr_need_q [DEPTH];
    logic [`HiCore_CSRIDX_WIDTH-1:0] csr_idx_q  [DEPTH];
    logic                            fence_i_q  [DEPTH];
    logic                            mret_q     [DEPTH];
    logic [`HiCore_PC_SIZE-1:0]      pc_q       [DEPTH];
    logic [`HiCore_REG_SIZE-1:0]     rd_data_q  [DEPTH];
    logic [`HiCore_REG_SIZE-1:0]     csr_data_q [DEPTH];
    logic [`HiCore_PC_SIZE-1:0]      next_pc_q  [DEPTH];
    logic [`HiCore_EXCP_SIZE-1:0]    excp_q     [DEPTH];
    logic [`HiCore_IRQ_SIZE-1:0]     irq_q      [DEPTH];
    logic disp_fire, commit_fire, wb_hit;

    assign disp_ready     = (count != (TAG_W+1)'(DEPTH)) & ~flush;
    assign disp_tag       = tail;
    assign disp_fire      = disp_valid & disp_ready;
    assign rob_ready      = valid[head] & done[head];
    assign commit_fire    = rob_valid & rob_ready;
    assign wb_hit         = wb_valid & valid[wb_tag];
    assign rob_rd_need    = rd_need_q[head];
    assign rob_rd_idx     = rd_idx_q[head];
    assign rob_rd_data    = rd_data_q[head];
    assign rob_csr_need   = csr_need_q[head];
    assign rob_csr_idx    = csr_idx_q[head];
    assign rob_csr_data   = csr_data_q[head];
    assign rob_fence_i_op = fence_i_q[head];
    assign rob_mret_op    = mret_q[head];
    assign rob_next_pc    = next_pc_q[head];
    assign rob_info       = {pc_q[head], irq_q[head], excp_q[head]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_need_q[i]  <= 1'b0;
                rd_idx_q[i]   <= '0;
                csr_need_q[i] <= 1'b0;
                csr_idx_q[i]  <= '0;
                fence_i_q[i]  <= 1'b0;
                mret_q[i]     <= 1'b0;
                pc_q[i]       <= '0;
                rd_data_q[i]  <= '0;
                csr_data_q[i] <= '0;
                next_pc_q[i]  <= '0;
                excp_q[i]     <= '0;
                irq_q[i]      <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            // The tail slot is never valid while dispatch fires, so these writes cannot collide
            if (disp_fire) begin
                rd_need_q[tail]  <= disp_rd_need;
                rd_idx_q[tail]   <= disp_rd_idx;
                csr_need_q[tail] <= disp_csr_need;
                csr_idx_q[tail]  <= disp_csr_idx;
                fence_i_q[tail]  <= disp_fence_i_op;
                mret_q[tail]     <= disp_mret_op;
                pc_q[tail]       <= disp_pc;
                valid[tail]      <= 1'b1;
                done[tail]       <= 1'b0;
                tail             <= tail + 1'b1;
            end
            if (wb_hit) begin
                rd_data_q[wb_tag]  <= wb_rd_data;
                csr_data_q[wb_tag] <= wb_csr_data;
                next_pc_q[wb_tag]  <= wb_next_pc;
                excp_q[wb_tag]     <= wb_excp;
                irq_q[wb_tag]      <= wb_irq;
                done[wb_tag]       <= 1'b1;
            end
            if (commit_fire) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(commit_fire);
        end
    end
endmodule

// File: tb/tb_hicore_rob.sv
// tb_hicore_rob: directed scenarios plus random traffic against a queue-based program-order model
`ifndef HiCore_RFIDX_WIDTH
`define HiCore_RFIDX_WIDTH 5
`endif
`ifndef HiCore_CSRIDX_WIDTH
`define HiCore_CSRIDX_WIDTH 12
`endif
`ifndef HiCore_PC_SIZE
`define HiCore_PC_SIZE 32
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_EXCP_SIZE
`define HiCore_EXCP_SIZE 8
`endif
`ifndef HiCore_IRQ_SIZE
`define HiCore_IRQ_SIZE 3
`endif
`ifndef HiCore_WB_SIZE
`define HiCore_WB_SIZE (`HiCore_PC_SIZE + `HiCore_IRQ_SIZE + `HiCore_EXCP_SIZE)
`endif

module tb_hicore_rob;
    localparam int DEPTH = 8;
    logic clk = 0, rst_n = 0;
    logic disp_valid = 0, disp_ready, disp_rd_need = 0, disp_csr_need = 0;
    logic disp_fence_i_op = 0, disp_mret_op = 0;
    logic [4:0]  disp_rd_idx = 0;
    logic [11:0] disp_csr_idx = 0;
    logic [31:0] disp_pc = 0;
    logic [2:0]  disp_tag, wb_tag = 0;
    logic        wb_valid = 0;
    logic [31:0] wb_rd_data = 0, wb_csr_data = 0, wb_next_pc = 0;
    logic [7:0]  wb_excp = 0;
    logic [2:0]  wb_irq = 0;
    logic        rob_valid = 0, rob_ready, rob_rd_need, rob_csr_need, rob_fence_i_op, rob_mret_op;
    logic [4:0]  rob_rd_idx;
    logic [11:0] rob_csr_idx;
    logic [31:0] rob_rd_data, rob_csr_data, rob_next_pc;
    logic [42:0] rob_info;
    logic        flush = 0;

    hicore_rob #(.DEPTH(8), .TAG_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_rd_need(disp_rd_need), .disp_rd_idx(disp_rd_idx),
        .disp_csr_need(disp_csr_need), .disp_csr_idx(disp_csr_idx),
        .disp_fence_i_op(disp_fence_i_op), .disp_mret_op(disp_mret_op),
        .disp_pc(disp_pc), .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_rd_data(wb_rd_data),
        .wb_csr_data(wb_csr_data), .wb_next_pc(wb_next_pc), .wb_excp(wb_excp), .wb_irq(wb_irq),
        .rob_valid(rob_valid), .rob_ready(rob_ready),
        .rob_rd_need(rob_rd_need), .rob_rd_idx(rob_rd_idx), .rob_rd_data(rob_rd_data),
        .rob_csr_need(rob_csr_need), .rob_csr_idx(rob_csr_idx), .rob_csr_data(rob_csr_data),
        .rob_fence_i_op(rob_fence_i_op), .rob_mret_op(rob_mret_op),
        .rob_next_pc(rob_next_pc), .rob_info(rob_info), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  tag;
        logic        rd_need;
        logic [4:0]  rd_idx;
        logic        csr_need;
        logic [11:0] csr_idx;
        logic        fence_i, mret;
        logic [31:0] pc;
        logic        done;
        logic [31:0] rd_data, csr_data, next_pc;
        logic [7:0]  excp;
        logic [2:0]  irq;
    } ent_t;

    ent_t q[$];
    logic [2:0] next_tag = 0;
    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        disp_valid = 0; wb_valid = 0; rob_valid = 0; flush = 0;
    endtask

    task automatic set_disp(input logic [31:0] pc);
        disp_valid = 1; disp_pc = pc;
        disp_rd_need = 1'($urandom); disp_rd_idx = 5'($urandom);
        disp_csr_need = 1'($urandom); disp_csr_idx = 12'($urandom);
        disp_fence_i_op = 1'($urandom); disp_mret_op = 1'($urandom);
    endtask

    task automatic set_wb(input logic [2:0] tag);
        wb_valid = 1; wb_tag = tag;
        wb_rd_data = $urandom; wb_csr_data = $urandom; wb_next_pc = $urandom;
        wb_excp = 8'($urandom); wb_irq = 3'($urandom);
    endtask

    // Check the current cycle against the model, then advance the model across one clock edge
    task automatic tick();
        bit edr, err, df, cf;
        ent_t e;
        #1;
        edr = (q.size() < DEPTH) && !flush;
        err = (q.size() > 0) && q[0].done;
        check("disp_ready", 64'(disp_ready), 64'(edr));
        check("disp_tag", 64'(disp_tag), 64'(next_tag));
        check("rob_ready", 64'(rob_ready), 64'(err));
        if (err) begin
            e = q[0];
            check("rob_info", 64'(rob_info), 64'({e.pc, e.irq, e.excp}));
            check("rob_next_pc", 64'(rob_next_pc), 64'(e.next_pc));
            check("rob_rd", 64'({rob_rd_need, rob_rd_idx, rob_rd_data}), 64'({e.rd_need, e.rd_idx, e.rd_data}));
            check("rob_csr", 64'({rob_csr_need, rob_csr_idx, rob_csr_data}), 64'({e.csr_need, e.csr_idx, e.csr_data}));
            check("rob_ops", 64'({rob_fence_i_op, rob_mret_op}), 64'({e.fence_i, e.mret}));
        end
        df = disp_valid && edr;
        cf = rob_valid && err;
        @(posedge clk);
        if (flush) begin
            q.delete();
            next_tag = 0;
        end else begin
            if (wb_valid)
                foreach (q[i])
                    if (q[i].tag == wb_tag) begin
                        q[i].done = 1; q[i].rd_data = wb_rd_data; q[i].csr_data = wb_csr_data;
                        q[i].next_pc = wb_next_pc; q[i].excp = wb_excp; q[i].irq = wb_irq;
                    end
            if (cf) void'(q.pop_front());
            if (df) begin
                e = '0;
                e.tag = next_tag; e.rd_need = disp_rd_need; e.rd_idx = disp_rd_idx;
                e.csr_need = disp_csr_need; e.csr_idx = disp_csr_idx;
                e.fence_i = disp_fence_i_op; e.mret = disp_mret_op; e.pc = disp_pc;
                q.push_back(e);
                next_tag++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_rob_ready", 64'(rob_ready), 0);
        check("rst_disp_ready", 64'(disp_ready), 1);
        check("rst_disp_tag", 64'(disp_tag), 0);
        check("rst_rob_fields", 64'({rob_info, rob_rd_need, rob_csr_need, rob_fence_i_op, rob_mret_op}), 0);
        check("rst_rob_data", 64'({rob_rd_data, rob_next_pc}), 0);
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            set_disp(32'h100 + 32'(4 * i));
            #1 check("t1_tag", 64'(disp_tag), 64'(i));
            tick();
        end
        idle();
        set_wb(3'd1); tick();
        set_wb(3'd0); tick();
        idle();
        #1 check("t2_ready", 64'(rob_ready), 1);
        check("t2_pc0", 64'(rob_info[42:11]), 64'h100);
        rob_valid = 1; tick();
        #1 check("t2_pc1", 64'(rob_info[42:11]), 64'h104);
        tick();
        #1 check("t2_wait", 64'(rob_ready), 0);
        idle(); flush = 1; tick(); idle();

        for (int i = 0; i < 8; i++) begin set_disp(32'h1000 + 32'(4 * i)); tick(); end
        idle();
        #1 check("t3_full", 64'(disp_ready), 0);
        for (int i = 0; i < 8; i++) begin set_wb(3'(i)); tick(); end
        idle();
        set_disp(32'h2000); rob_valid = 1; tick();
        idle();
        #1 check("t3_reopen", 64'(disp_ready), 1);
        check("t3_tag", 64'(disp_tag), 0);
        flush = 1; tick(); idle();

        for (int i = 0; i < 20; i++) begin
            set_disp(32'h3000 + 32'(4 * i)); tick(); idle();
            set_wb(next_tag - 3'd1); rob_valid = 1; tick(); idle();
        end
        rob_valid = 1; tick(); idle();

        flush = 1; tick(); idle();
        set_disp(32'h200); tick(); idle();
        set_wb(3'd0); wb_excp = 8'h01; wb_irq = 3'b101; tick(); idle();
        #1 check("t5_info", 64'(rob_info), 64'({32'h200, 3'b101, 8'h01}));
        check("t5_ready", 64'(rob_ready), 1);
        flush = 1; tick(); idle();
        #1 check("t5_flushed", 64'(rob_ready), 0);
        check("t5_tag", 64'(disp_tag), 0);

        set_wb(3'd5); wb_rd_data = 32'hDEAD; tick(); idle();
        for (int i = 0; i < 6; i++) begin set_disp(32'h4000 + 32'(4 * i)); tick(); end
        idle();
        for (int i = 0; i < 5; i++) begin set_wb(3'(i)); tick(); end
        idle();
        rob_valid = 1;
        repeat (5) tick();
        idle();
        #1 check("t6_not_done", 64'(rob_ready), 0);
        set_wb(3'd5); tick(); idle();
        rob_valid = 1; tick(); idle();

        for (int n = 0; n < 500; n++) begin
            idle();
            if ($urandom_range(1, 0) != 0) set_disp($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(3, 0) != 0) begin
                if (q.size() > 0 && $urandom_range(3, 0) != 0)
                    set_wb(q[$urandom_range(q.size() - 1, 0)].tag);
                else
                    set_wb(3'($urandom));
            end
            rob_valid = 1'($urandom);
            flush = ($urandom_range(39, 0) == 0);
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
